time_field_counter: RTL

TIME_FIELD_COUNTER -- requirements
Module: time_field_counter

---
 rtl/time_pkg.sv | 19 +
 rtl/key_repeat.sv | 99 +++++++++
 rtl/time_field_counter.sv | 75 +++++++
 3 files changed

// File: rtl/time_pkg.sv
// rtl/time_pkg.sv - shared types and wrap arithmetic for time field counters
package time_pkg;

  typedef enum logic [1:0] {
    KEY_IDLE,
    KEY_FIRST,
    KEY_DELAY,
    KEY_REPEAT
  } key_state_t;

  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned modulus);
    return (v == modulus - 1) ? 0 : v + 1;
  endfunction

  function automatic int unsigned wrap_dec(input int unsigned v, input int unsigned modulus);
    return (v == 0) ? modulus - 1 : v - 1;
  endfunction

endpackage

// File: rtl/key_repeat.sv
// rtl/key_repeat.sv - set-key auto-repeat FSM producing single-cycle step pulses
module key_repeat
  import time_pkg::*;
#(
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_up,
  input  logic set_down,
  output logic step_up,
  output logic step_down
);

  localparam int TIMER_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
  localparam logic [TIMER_W-1:0] DELAY_LAST = TIMER_W'(REPEAT_DELAY - 1);
  localparam logic [TIMER_W-1:0] RATE_LAST  = TIMER_W'(REPEAT_RATE - 1);

  if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_timing
    $error("key_repeat: REPEAT_DELAY and REPEAT_RATE must be >= 1");
  end

  key_state_t         state, state_nxt;
  logic               dir, dir_nxt;
  logic [TIMER_W-1:0] timer, timer_nxt;
  logic               step;
  logic               active;
  logic               same_key;

  assign active   = set_up ^ set_down;
  assign same_key = active && (set_up == dir);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= KEY_IDLE;
      dir   <= 1'b0;
      timer <= '0;
    end else begin
      state <= state_nxt;
      dir   <= dir_nxt;
      timer <= timer_nxt;
    end
  end

  // The press that moved us into FIRST is committed, so FIRST always steps.
  always_comb begin
    state_nxt = state;
    dir_nxt   = dir;
    timer_nxt = timer;
    step      = 1'b0;
    case (state)
      KEY_IDLE: begin
        timer_nxt = '0;
        if (active) begin
          state_nxt = KEY_FIRST;
          dir_nxt   = set_up;
        end
      end
      KEY_FIRST: begin
        step      = 1'b1;
        timer_nxt = '0;
        state_nxt = same_key ? KEY_DELAY : KEY_IDLE;
      end
      KEY_DELAY: begin
        if (!same_key) begin
          state_nxt = KEY_IDLE;
          timer_nxt = '0;
        end else if (timer == DELAY_LAST) begin
          step      = 1'b1;
          state_nxt = KEY_REPEAT;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + TIMER_W'(1);
        end
      end
      KEY_REPEAT: begin
        if (!same_key) begin
          state_nxt = KEY_IDLE;
          timer_nxt = '0;
        end else if (timer == RATE_LAST) begin
          step      = 1'b1;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + TIMER_W'(1);
        end
      end
      default: begin
        state_nxt = KEY_IDLE;
        timer_nxt = '0;
      end
    endcase
  end

  assign step_up   = step & dir;
  assign step_down = step & ~dir;

endmodule

// File: rtl/time_field_counter.sv
// rtl/time_field_counter.sv - modulo time field with tick carry, load and auto-repeat set keys
module time_field_counter
  import time_pkg::*;
#(
  parameter int WIDTH        = 7,
  parameter int MODULUS      = 60,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             set_up,
  input  logic             set_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] value,
  output logic             carry
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
    $error("time_field_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  logic             step_up;
  logic             step_down;
  logic [WIDTH-1:0] inc_val;
  logic [WIDTH-1:0] dec_val;
  logic [WIDTH-1:0] value_nxt;
  logic             carry_nxt;

  key_repeat #(
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE)
  ) u_key_repeat (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_up   (set_up),
    .set_down (set_down),
    .step_up  (step_up),
    .step_down(step_down)
  );

  assign inc_val = WIDTH'(wrap_inc(32'(value), 32'(MODULUS)));
  assign dec_val = WIDTH'(wrap_dec(32'(value), 32'(MODULUS)));

  // One action per cycle; a tick losing to load or a key step is dropped.
  always_comb begin
    value_nxt = value;
    carry_nxt = 1'b0;
    if (load) begin
      value_nxt = (32'(load_val) < 32'(MODULUS)) ? load_val : MAX_VAL;
    end else if (step_up) begin
      value_nxt = inc_val;
    end else if (step_down) begin
      value_nxt = dec_val;
    end else if (tick) begin
      value_nxt = inc_val;
      carry_nxt = (value == MAX_VAL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
      carry <= 1'b0;
    end else begin
      value <= value_nxt;
      carry <= carry_nxt;
    end
  end

endmodule
